// File: rtl/spring_pkg.sv
// Shared constants and types for the adder-tree operand path.
// Lane count, counter width, word-length helper and lane-vector type.
package spring_pkg;

    localparam int NLANE = 16;
    localparam int CNTW  = $clog2(NLANE);

    function automatic int wl(input int il, input int fl);
        return (il + fl) * 2;
    endfunction

    localparam int WL_DEF = wl(8, 12);

    typedef logic [NLANE-1:0][WL_DEF-1:0] lane_vec_t;

endpackage

// File: rtl/vec_feeder.sv
// Serial-to-parallel feeder: packs 16 product beats into one tree vector.
// Optional partial vectors (zero-padded) with `define VEC_FEEDER_PAD_EN.
module vec_feeder
    import spring_pkg::*;
#(
    parameter int IL = 8,
    parameter int FL = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [wl(IL,FL)-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
`ifdef VEC_FEEDER_PAD_EN
    input  logic                        s_last,
`endif
    output logic [NLANE*wl(IL,FL)-1:0]  o_vec,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [4:0]                  o_count
);

    localparam int W = wl(IL, FL);

    typedef logic [NLANE-1:0][W-1:0] vec_t;

    vec_t            asm_q, asm_n;
    vec_t            vec_q, vec_n;
    vec_t            fill;
    logic [CNTW-1:0] cnt_q, cnt_n;
    logic            valid_q, valid_n;
    logic            full_q, full_n;
    logic            ready_q, ready_n;
    logic [4:0]      count_q, count_n;
    logic [4:0]      lane_count;
    logic            take;
    logic            done;
    logic            out_free;

    assign take     = s_valid && ready_q;
    assign out_free = !valid_q || o_ready;

`ifdef VEC_FEEDER_PAD_EN
    assign done       = (cnt_q == CNTW'(NLANE-1)) || s_last;
    assign lane_count = {1'b0, cnt_q} + 5'd1;
`else
    assign done       = (cnt_q == CNTW'(NLANE-1));
    assign lane_count = 5'(NLANE);
`endif

    always_comb begin
        asm_n   = asm_q;
        vec_n   = vec_q;
        cnt_n   = cnt_q;
        valid_n = valid_q;
        full_n  = full_q;
`ifdef VEC_FEEDER_PAD_EN
        count_n = count_q;
`else
        count_n = 5'(NLANE);
`endif
        fill        = asm_q;
        fill[cnt_q] = s_data;

        if (valid_q && o_ready)
            valid_n = 1'b0;

        // A held vector has priority; the source is stalled while it waits.
        if (full_q) begin
            if (valid_q && o_ready) begin
                vec_n   = asm_q;
                valid_n = 1'b1;
                count_n = lane_count;
                full_n  = 1'b0;
                cnt_n   = '0;
                asm_n   = '0;
            end
        end else if (take) begin
            if (done && out_free) begin
                vec_n   = fill;
                valid_n = 1'b1;
                count_n = lane_count;
                cnt_n   = '0;
                asm_n   = '0;
            end else if (done) begin
                asm_n  = fill;
                full_n = 1'b1;
            end else begin
                asm_n = fill;
                cnt_n = cnt_q + 1'b1;
            end
        end

        ready_n = !full_n;
    end

    // Cleared assembly lanes double as the zero padding of short vectors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            count_q <= '0;
        end else begin
            asm_q   <= asm_n;
            vec_q   <= vec_n;
            cnt_q   <= cnt_n;
            valid_q <= valid_n;
            full_q  <= full_n;
            ready_q <= ready_n;
            count_q <= count_n;
        end
    end

    assign o_vec   = vec_q;
    assign o_valid = valid_q;
    assign s_ready = ready_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_vec_feeder.sv
// Directed bench for vec_feeder (IL=8, FL=12, 40-bit lanes).
// Define VEC_FEEDER_PAD_EN to also exercise short zero-padded vectors.
module tb_vec_feeder;

    localparam int W  = 40;
    localparam int NL = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [W-1:0]    s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic            s_last = 1'b0;
    logic [NL*W-1:0] o_vec;
    logic            o_valid;
    logic            o_ready = 1'b0;
    logic [4:0]      o_count;

    int npass = 0;
    int ntot  = 0;
    int stalls = 0;
    int cyc = 0;

    logic [NL*W-1:0] q_vec[$];
    int              q_cyc[$];

    vec_feeder #(.IL(8), .FL(12)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
`ifdef VEC_FEEDER_PAD_EN
        .s_last  (s_last),
`endif
        .o_vec   (o_vec),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every consumed vector with the cycle it was taken.
    always begin
        @(negedge clk);
        #1;
        if (o_valid && o_ready) begin
            q_vec.push_back(o_vec);
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [W-1:0] lane(input logic [NL*W-1:0] v,
                                          input int k);
        return v[k*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ntot++;
        if (got === exp)
            npass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic put(input logic [W-1:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            chk("put_timeout", 64'(n), 64'd0);
        stalls += n;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        logic [NL*W-1:0] v;

        // 1: reset state, then one 16-beat vector
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_vec0", 64'(lane(o_vec, 0)), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_rise", 64'(s_ready), 64'd1);
        o_ready = 1'b1;
        for (int i = 1; i <= 15; i++) put(40'(i), 1'b0);
        chk("t1_not_yet", 64'(o_valid), 64'd0);
        put(40'd16, 1'b0);
        chk("t1_valid", 64'(o_valid), 64'd1);
        chk("t1_lane0", 64'(lane(o_vec, 0)), 64'd1);
        chk("t1_lane7", 64'(lane(o_vec, 7)), 64'd8);
        chk("t1_lane15", 64'(lane(o_vec, 15)), 64'd16);
        chk("t1_count", 64'(o_count), 64'd16);
        @(negedge clk);
        chk("t1_drop", 64'(o_valid), 64'd0);

        // 2: 32 back-to-back beats, two vectors 16 cycles apart
        q_vec.delete();
        q_cyc.delete();
        stalls = 0;
        for (int i = 1; i <= 32; i++) put(40'(100 + i), 1'b0);
        repeat (2) @(negedge clk);
        chk("t2_nvec", 64'(q_vec.size()), 64'd2);
        chk("t2_stalls", 64'(stalls), 64'd0);
        if (q_vec.size() == 2) begin
            chk("t2_gap", 64'(q_cyc[1] - q_cyc[0]), 64'd16);
            chk("t2_a0", 64'(lane(q_vec[0], 0)), 64'd101);
            chk("t2_a15", 64'(lane(q_vec[0], 15)), 64'd116);
            chk("t2_b0", 64'(lane(q_vec[1], 0)), 64'd117);
            chk("t2_b15", 64'(lane(q_vec[1], 15)), 64'd132);
        end

        // 3: downstream stalled, second vector held in assembly
        o_ready = 1'b0;
        q_vec.delete();
        q_cyc.delete();
        for (int i = 1; i <= 32; i++) put(40'(200 + i), 1'b0);
        chk("t3_ready_lo", 64'(s_ready), 64'd0);
        chk("t3_valid", 64'(o_valid), 64'd1);
        repeat (3) @(negedge clk);
        chk("t3_hold0", 64'(lane(o_vec, 0)), 64'd201);
        chk("t3_hold15", 64'(lane(o_vec, 15)), 64'd216);
        chk("t3_hold_rdy", 64'(s_ready), 64'd0);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        chk("t3_next0", 64'(lane(o_vec, 0)), 64'd217);
        chk("t3_next15", 64'(lane(o_vec, 15)), 64'd232);
        chk("t3_next_vld", 64'(o_valid), 64'd1);
        chk("t3_ready_hi", 64'(s_ready), 64'd1);
        o_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_drain", 64'(o_valid), 64'd0);
        chk("t3_nvec", 64'(q_vec.size()), 64'd2);

        // 4: signed extremes pass bit-exact
        put(40'h80_0000_0000, 1'b0);
        for (int i = 1; i <= 14; i++) put(40'(i), 1'b0);
        put(40'hFF_FFFF_FFFF, 1'b0);
        chk("t4_min", 64'(lane(o_vec, 0)), 64'h80_0000_0000);
        chk("t4_neg1", 64'(lane(o_vec, 15)), 64'hFF_FFFF_FFFF);
        chk("t4_mid", 64'(lane(o_vec, 14)), 64'd14);

        // 5: reset mid-vector discards the partial assembly
        @(negedge clk);
        q_vec.delete();
        q_cyc.delete();
        for (int i = 1; i <= 7; i++) put(40'd55, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_vld", 64'(o_valid), 64'd0);
        chk("t5_rst_rdy", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) put(40'd100, 1'b0);
        repeat (2) @(negedge clk);
        chk("t5_nvec", 64'(q_vec.size()), 64'd1);
        if (q_vec.size() >= 1) begin
            v = q_vec[0];
            for (int k = 0; k < NL; k++)
                chk($sformatf("t5_lane%0d", k), 64'(lane(v, k)), 64'd100);
        end

`ifdef VEC_FEEDER_PAD_EN
        // 6: short vector closed by s_last is zero-padded
        for (int i = 0; i < 4; i++) put(40'(7 + i), 1'b0);
        put(40'd11, 1'b1);
        chk("t6_valid", 64'(o_valid), 64'd1);
        chk("t6_count", 64'(o_count), 64'd5);
        chk("t6_lane0", 64'(lane(o_vec, 0)), 64'd7);
        chk("t6_lane4", 64'(lane(o_vec, 4)), 64'd11);
        chk("t6_lane5", 64'(lane(o_vec, 5)), 64'd0);
        chk("t6_lane15", 64'(lane(o_vec, 15)), 64'd0);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
